// File: rtl/recv.sv
// recv: 8N1 UART receiver.
//   Deserialises start + 8 data bits (LSB first) + stop bit from UART_RX at one
//   bit per `wtime` clocks, sampling each bit near its midpoint.
// Ports:
//   CLK      in   clock, rising edge
//   RESET    in   synchronous, active-high reset
//   UART_RX  in   asynchronous serial line, idle high
//   ack      in   consumer has taken `data` (ignored while valid = 0)
//   data     out  last received byte, held until overwritten
//   valid    out  unread byte present
//   busy     out  frame in progress
//   ferr     out  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun  out  one-cycle pulse: byte completed while an unread byte was pending
module recv #(
    parameter int unsigned wtime = 32'h28B0  // clocks per bit, must be >= 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       UART_RX,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       ferr,
    output logic       overrun
);

    localparam logic [31:0] HalfM1  = 32'(wtime >> 1) - 32'd1;
    localparam logic [31:0] WtimeM1 = 32'(wtime) - 32'd1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q, state_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [31:0] clk_count_q, clk_count_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        overrun_q, overrun_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            clk_count_q <= 32'd0;
            bit_idx_q   <= 4'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_s1_q     <= UART_RX;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            clk_count_q <= clk_count_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q + 32'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        ferr_d      = 1'b0;
        overrun_d   = 1'b0;

        // A byte completing on this same edge overrides the clear below.
        if (valid_q && ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                // Only a high->low transition starts a frame; a held-low line does not.
                if (!rx_s2_q && rx_prev_q) begin
                    state_d     = StStart;
                    clk_count_d = 32'd0;
                end
            end
            StStart: begin
                if (clk_count_q == HalfM1) begin
                    clk_count_d = 32'd0;
                    state_d     = rx_s2_q ? StIdle : StData;  // high here means a glitch
                    bit_idx_d   = 4'd0;
                end
            end
            StData: begin
                if (clk_count_q == WtimeM1) begin
                    clk_count_d = 32'd0;
                    shift_d     = {rx_s2_q, shift_q[7:1]};
                    bit_idx_d   = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (clk_count_q == WtimeM1) begin
                    clk_count_d = 32'd0;
                    state_d     = StIdle;
                    if (rx_s2_q) begin
                        data_d    = shift_q;
                        valid_d   = 1'b1;
                        overrun_d = valid_q && !ack;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign busy    = (state_q != StIdle);
    assign ferr    = ferr_q;
    assign overrun = overrun_q;

endmodule
